booth_mult_seq: RTL
===================

Name: booth_mult_seq

Overview:
- Multi-cycle signed multiplier built on radix-2 Booth recoding.
- Sequences a single shared signed_adder instance (add/sub datapath) over WIDTH iterations.
- Sits beside the integer adder in the ALU and provides the MUL operation.
- Start/busy/done handshake to the ALU control; full 2*WIDTH-bit product plus status flags.

Parameters:
- WIDTH, 8, operand width in bits; legal values are WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when busy=0.
- x  input  WIDTH  multiplicand, two's complement; captured on accept.
- y  input  WIDTH  multiplier, two's complement; captured on accept.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when product is valid.
- p  output  2*WIDTH  signed product; held until next completion.
- negative  output  1  p[2*WIDTH-1], registered with p.
- zero  output  1  p == 0, registered with p.

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk, reset.
- Reset values: state=IDLE, busy=0, done=0, p=0, negative=0, zero=1, counter=0, all internal regs=0.
- Reset asserted mid-operation aborts the multiply the next edge. No done is issued; p returns to 0.
- States: IDLE and RUN. done is a separate registered pulse, not a state.
- IDLE with start=1 (the accept edge):
  - Load A=0 (WIDTH+1 bits), Q=y, q_1=0, M=sign-extended x (WIDTH+1 bits), count=WIDTH.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge performs one Booth step on {Q[0],q_1}:
  - 01: A' = A + M (adder add_sub=0).
  - 10: A' = A - M (adder add_sub=1).
  - 00/11: A' = A. The adder is still driven, but its result is discarded.
  - Then arithmetic shift right of {A',Q,q_1} by 1; A's MSB is replicated.
  - count decrements by 1.
- Completion: on the RUN edge where count==1:
  - The step completes normally.
  - p <= {A[WIDTH-1:0],Q} taken from the shifted result; flags are computed from the same value.
  - done <= 1; state <= IDLE; busy <= 0.
- Latency: done is high in the cycle after the WIDTH-th edge following the accept edge, i.e. WIDTH+1 edges from the accept edge. Throughput is one multiply per WIDTH+1 cycles.
- Back-to-back: start held high in the done cycle is accepted, since state is IDLE. done and busy are never both high.
- start while busy=1 is ignored. x and y changes during RUN have no effect, because the operands are registered.
- Accumulator width is WIDTH+1, so A - M never overflows, including the M = -2^(WIDTH-1) case. The adder is instantiated with WIDTH+1. Its overflow and cout outputs are left unconnected.
- Arithmetic: the product is exact for all operand pairs. Range is -2^(2W-2)+2^(W-1) .. 2^(2W-2); no overflow flag is produced.
- done deasserts after exactly one cycle. p, negative and zero hold until the next completion or reset.

Decomposition:
- Shared package (alu_pkg) holds:
  - state encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1;
  - Booth decode constants BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11.
- Sub-module: the existing signed_adder, instantiated once as u_add with WIDTH+1.
- No other sub-modules. Counter, FSM and shift register stay in booth_mult_seq.

Test Plan:
- WIDTH=8, reset 2 cycles then x=3, y=5, start 1 cycle:
  - done pulses exactly 9 edges after the accept edge;
  - p=16'h000F, negative=0, zero=0; busy high for 8 cycles.
- x=-7 (8'hF9), y=6 -> p=16'hFFD6 (-42), negative=1, zero=0.
- Corner operands:
  - x=-128, y=-128 -> p=16'h4000 (16384);
  - x=127, y=-128 -> p=16'hC080 (-16256).
  - These verify the WIDTH+1 accumulator.
- x=0, y=8'h5A -> p=0, zero=1. Then start held high across the done cycle with x=2, y=-1: second accept occurs in the done cycle and the next done gives p=16'hFFFE.
- Mid-run disturbances:
  - Pulse start again and change x/y 3 cycles into a run: the result is unaffected and no extra done occurs.
  - Assert reset at iteration 4 of a run: the next cycle has busy=0, done=0, p=0, zero=1.
  - No done follows until a new start.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions: multiplier FSM states and Booth
//               radix-2 decode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Multiplier sequencer states; done is a separate registered pulse.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Booth decode of {Q[0], q_1}
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/signed_adder.sv
`default_nettype none
// ============================================================================
// Module      : signed_adder
// Description : Two's complement add/subtract datapath. i_add_sub=0 adds,
//               i_add_sub=1 subtracts (i_a - i_b). Provides carry-out and
//               signed overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_add_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  // Subtraction is addition of the one's complement plus a carry-in of one.
  assign w_b_eff    = i_b ^ {WIDTH{i_add_sub}};
  assign w_full     = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_add_sub};
  assign o_sum      = w_full[WIDTH-1:0];
  assign o_cout     = w_full[WIDTH];
  // Signed overflow: both effective operands share a sign the sum does not.
  assign o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule : signed_adder
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq
// Description : Multi-cycle signed multiplier, radix-2 Booth recoding. One
//               shared add/sub datapath is stepped WIDTH times per multiply.
//               start/busy/done handshake; 2*WIDTH-bit product with
//               negative/zero flags registered alongside it.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p,
  output logic                 negative,
  output logic                 zero
);

  // Sequencer state
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  // Booth datapath: accumulator is one bit wider than the operands so that
  // A - M cannot overflow even for M = -2^(WIDTH-1).
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_q1;
  logic [WIDTH:0]     r_m;
  logic [CNT_W-1:0]   r_cnt;

  // Result registers
  logic [2*WIDTH-1:0] r_p;
  logic               r_neg;
  logic               r_zero;
  logic               r_done;

  logic [1:0]         w_booth;
  logic               w_sub;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_a_step;
  logic [WIDTH:0]     w_a_shift;
  logic [WIDTH-1:0]   w_q_shift;
  logic [2*WIDTH-1:0] w_prod;

  assign w_booth = {r_q[0], r_q1};
  assign w_sub   = (w_booth == BOOTH_SUB);

  // The adder is always driven; its result is used only on ADD/SUB steps.
  signed_adder #(
    .WIDTH (WIDTH + 1)
  ) u_add (
    .i_a        (r_a),
    .i_b        (r_m),
    .i_add_sub  (w_sub),
    .o_sum      (w_sum),
    .o_cout     (),
    .o_overflow ()
  );

  assign w_a_step  = ((w_booth == BOOTH_ADD) || (w_booth == BOOTH_SUB)) ? w_sum : r_a;
  // Arithmetic right shift of {A', Q, q_1}: A's MSB is replicated.
  assign w_a_shift = {w_a_step[WIDTH], w_a_step[WIDTH:1]};
  assign w_q_shift = {w_a_step[0], r_q[WIDTH-1:1]};
  // Product is {A[WIDTH-1:0], Q} of the shifted value.
  assign w_prod    = {w_a_shift[WIDTH-1:0], w_q_shift};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: accept in IDLE, leave RUN on the final iteration
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand load, Booth iteration, and result capture on the final step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_q    <= '0;
      r_q1   <= 1'b0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_p    <= '0;
      r_neg  <= 1'b0;
      r_zero <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a   <= '0;
        r_q   <= y;
        r_q1  <= 1'b0;
        r_m   <= {x[WIDTH-1], x};
        r_cnt <= CNT_W'(WIDTH);
      end else if (r_state == ST_RUN) begin
        r_a   <= w_a_shift;
        r_q   <= w_q_shift;
        r_q1  <= r_q[0];
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_p    <= w_prod;
          r_neg  <= w_prod[2*WIDTH-1];
          r_zero <= (w_prod == '0);
        end
      end
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign p        = r_p;
  assign negative = r_neg;
  assign zero     = r_zero;

endmodule : booth_mult_seq
`default_nettype wire
